// File: rtl/vga_timing_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_timing_pkg : default 640x480@60 timing constants and coordinate type   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package vga_timing_pkg;

  localparam int COORD_W   = 10;
  localparam int COORD_MAX = 1 << COORD_W;

  typedef logic [COORD_W-1:0] coord_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

  function automatic int axis_total(input int active, input int front,
                                    input int sync, input int back);
    return active + front + sync + back;
  endfunction

  localparam int H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
  localparam int V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

  // Sync windows are half-open: [START, END)
  localparam int HSYNC_START = DEF_H_ACTIVE + DEF_H_FRONT;
  localparam int HSYNC_END   = HSYNC_START + DEF_H_SYNC;
  localparam int VSYNC_START = DEF_V_ACTIVE + DEF_V_FRONT;
  localparam int VSYNC_END   = VSYNC_START + DEF_V_SYNC;

endpackage
`default_nettype wire

// File: rtl/vga_sync_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_sync_gen_if : raster timing bundle (syncs, visible flag, x/y, strobes) |
// | Optional frameCount under VGA_SYNC_FRAME_COUNT_EN.  Rev 1.0                 |
// +----------------------------------------------------------------------------+
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic   hsync;
  logic   vsync;
  logic   canDisplayImage;
  coord_t x;
  coord_t y;
  logic   lineStart;
  logic   frameStart;
`ifdef VGA_SYNC_FRAME_COUNT_EN
  logic [7:0] frameCount;
`endif

`ifdef VGA_SYNC_FRAME_COUNT_EN
  modport master (output hsync, vsync, canDisplayImage, x, y, lineStart, frameStart, frameCount);
  modport slave  (input  hsync, vsync, canDisplayImage, x, y, lineStart, frameStart, frameCount);
`else
  modport master (output hsync, vsync, canDisplayImage, x, y, lineStart, frameStart);
  modport slave  (input  hsync, vsync, canDisplayImage, x, y, lineStart, frameStart);
`endif

endinterface
`default_nettype wire

// File: rtl/sync_axis_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync_axis_counter : one raster axis counter with wrap/active/sync decode   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sync_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FRONT  = DEF_H_FRONT,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BACK   = DEF_H_BACK
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic advance,
  output coord_t    count,
  output logic      wrap,
  output logic      active,
  output logic      sync_win
);

  localparam int     TOTAL      = axis_total(ACTIVE, FRONT, SYNC, BACK);
  localparam coord_t LAST       = coord_t'(TOTAL - 1);
  localparam coord_t ACTIVE_END = coord_t'(ACTIVE);
  localparam coord_t SYNC_START = coord_t'(ACTIVE + FRONT);
  localparam coord_t SYNC_END   = coord_t'(ACTIVE + FRONT + SYNC);

  coord_t r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (advance) begin
      r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
    end
  end

  assign count    = r_count;
  assign wrap     = advance && (r_count == LAST);
  assign active   = (r_count < ACTIVE_END);
  assign sync_win = (r_count >= SYNC_START) && (r_count < SYNC_END);

endmodule
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_sync_gen : 640x480@60 VGA raster generator with registered outputs     |
// | Optional frameCount output under VGA_SYNC_FRAME_COUNT_EN.  Rev 1.0          |
// +----------------------------------------------------------------------------+
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE        = DEF_H_ACTIVE,
  parameter int H_FRONT         = DEF_H_FRONT,
  parameter int H_SYNC          = DEF_H_SYNC,
  parameter int H_BACK          = DEF_H_BACK,
  parameter int V_ACTIVE        = DEF_V_ACTIVE,
  parameter int V_FRONT         = DEF_V_FRONT,
  parameter int V_SYNC          = DEF_V_SYNC,
  parameter int V_BACK          = DEF_V_BACK,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  wire logic       clock25MHz,
  input  wire logic       reset,
  vga_sync_gen_if.master  vga
);

  localparam int   H_TOT     = axis_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int   V_TOT     = axis_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
  localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

  if (H_TOT > COORD_MAX) begin : g_h_total_check
    $error("vga_sync_gen: horizontal total exceeds coordinate range");
  end
  if (V_TOT > COORD_MAX) begin : g_v_total_check
    $error("vga_sync_gen: vertical total exceeds coordinate range");
  end

  coord_t w_h_count;
  coord_t w_v_count;
  logic   w_h_wrap;
  logic   w_v_wrap;
  logic   w_h_active;
  logic   w_v_active;
  logic   w_h_sync;
  logic   w_v_sync;

  sync_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FRONT  (H_FRONT),
    .SYNC   (H_SYNC),
    .BACK   (H_BACK)
  ) u_h_axis (
    .clk      (clock25MHz),
    .rst      (reset),
    .advance  (1'b1),
    .count    (w_h_count),
    .wrap     (w_h_wrap),
    .active   (w_h_active),
    .sync_win (w_h_sync)
  );

  sync_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FRONT  (V_FRONT),
    .SYNC   (V_SYNC),
    .BACK   (V_BACK)
  ) u_v_axis (
    .clk      (clock25MHz),
    .rst      (reset),
    .advance  (w_h_wrap),
    .count    (w_v_count),
    .wrap     (w_v_wrap),
    .active   (w_v_active),
    .sync_win (w_v_sync)
  );

  // Counters hold the position to be presented on the next edge, so the
  // output stage lags them by one clock and shows (0,0) on the first edge.
  logic   r_origin;
  coord_t r_x;
  coord_t r_y;
  logic   r_display;
  logic   r_hsync;
  logic   r_vsync;
  logic   r_line_start;
  logic   r_frame_start;

  always_ff @(posedge clock25MHz or posedge reset) begin
    if (reset) begin
      r_origin      <= 1'b1;
      r_x           <= '0;
      r_y           <= '0;
      r_display     <= 1'b0;
      r_hsync       <= SYNC_IDLE;
      r_vsync       <= SYNC_IDLE;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_origin      <= w_v_wrap;
      r_x           <= w_h_count;
      r_y           <= w_v_count;
      r_display     <= w_h_active && w_v_active;
      r_hsync       <= w_h_sync ? ~SYNC_IDLE : SYNC_IDLE;
      r_vsync       <= w_v_sync ? ~SYNC_IDLE : SYNC_IDLE;
      r_line_start  <= (w_h_count == '0);
      r_frame_start <= r_origin;
    end
  end

  assign vga.x               = r_x;
  assign vga.y               = r_y;
  assign vga.canDisplayImage = r_display;
  assign vga.hsync           = r_hsync;
  assign vga.vsync           = r_vsync;
  assign vga.lineStart       = r_line_start;
  assign vga.frameStart      = r_frame_start;

`ifdef VGA_SYNC_FRAME_COUNT_EN
  // r_wrapped marks a real frame wrap; the post-reset origin never sets it.
  logic       r_wrapped;
  logic [7:0] r_frame_count;

  always_ff @(posedge clock25MHz or posedge reset) begin
    if (reset) begin
      r_wrapped     <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_wrapped <= w_v_wrap;
      if (r_wrapped) begin
        r_frame_count <= r_frame_count + 8'd1;
      end
    end
  end

  assign vga.frameCount = r_frame_count;
`endif

endmodule
`default_nettype wire
